ps2_link_scheduler: RTL and testbench
=====================================

// Module: ps2_link_scheduler
// PURPOSE
//  Time-multiplexes the single Arduino 4-bit button-code link between two PS2 controllers.
//  Drives the controller-select line, waits for the link to settle, and requires N identical
//  samples before publishing a code. Publishes one-hot button vectors c1/c2 to game logic.
//  Sits between GPIO_0 pins and game FSM.
// PARAMETERS
//  SETTLE_CYCLES  1000    cycles ignored after each sel_out change
//  SAMPLE_DIV     1000    cycles between code samples (sample on divider terminal count)
//  STABLE_COUNT   16      consecutive identical samples needed to publish (>=2)
//  MAX_SAMPLES    64      samples per slot before timeout (> STABLE_COUNT)
// PORTS
//  clock      in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  enable     in   1   1 = scheduler runs; 0 = hold
//  code_in    in   4   Arduino button code, asynchronous (GPIO_0[3:0])
//  sel_out    out  1   controller select to Arduino: 0 = controller 1, 1 = controller 2
//  c1         out  10  controller 1 one-hot button vector
//  c2         out  10  controller 2 one-hot button vector
//  c1_upd     out  1   1-cycle pulse: c1 written
//  c2_upd     out  1   1-cycle pulse: c2 written
//  err        out  1   1-cycle pulse: invalid code or slot timeout
// BEHAVIOUR
//  - One clock, synchronous active-high reset.
//  - Reset: sel_out=0, c1=c2=0, upd/err pulses=0, all counters=0, state=SETTLE.
//  - code_in passes a 2-flop synchronizer; all logic uses the synchronized code.
//  - SETTLE: settle counter runs 0..SETTLE_CYCLES-1; on the terminal count go to SAMPLE and clear
//    the divider/match/sample counters.
//  - SAMPLE: a sample is taken on each divider terminal count (SAMPLE_DIV-1).
//    First sample: candidate=code, match=1. Later sample equal to candidate: match++.
//    Later sample not equal: candidate=code, match=1. sample count++ on every sample.
//    match==STABLE_COUNT -> PUBLISH.
//    sample count==MAX_SAMPLES without stability -> TIMEOUT.
//  - PUBLISH (1 cycle): decode candidate.
//    code 0 = no button -> vector 0. Code k in 1..10 -> bit k-1 set
//    (1 CIRCLE, 2 CROSS, 3 SQUARE, 4 TRIANGLE, 5 LEFT, 6 RIGHT, 7 UP, 8 DOWN, 9 R1, 10 START).
//    Valid: write c1 (sel_out=0) or c2 (sel_out=1) next edge, pulse matching upd.
//    Codes 11..15: vector unchanged, no upd, err pulse.
//    Then toggle sel_out, go SETTLE.
//  - TIMEOUT (1 cycle): vector unchanged, err pulse, toggle sel_out, go SETTLE.
//  - Constant input latency: SETTLE entry to upd pulse = SETTLE_CYCLES + SAMPLE_DIV*STABLE_COUNT + 1.
//  - enable=0: in the same cycle, state forced to SETTLE with all counters cleared; sel_out, c1, c2
//    held; no pulses. Enable low mid-slot aborts the slot. Re-enable restarts SETTLE on the same sel_out.
//  - reset beats enable; reset mid-slot discards candidate and returns to controller 1.
//  - Counters sized $clog2(param+1); no wrap: every counter clears on state exit.
//  - upd and err are never both asserted in the same cycle.
// CONFIGURATION
//  PS2_PRESS_EDGE_EN defined: adds outputs c1_press[9:0], c2_press[9:0].
//    Each press output = new & ~old vector, pulsed for the single cycle its matching upd is high;
//    zero otherwise and on reset.
//  Undefined: no ports, no edge logic.
// STRUCTURE
//  ps2_pkg:
//    - state enum {SETTLE, SAMPLE, PUBLISH, TIMEOUT}
//    - button code localparams CODE_NONE..CODE_START, CODE_MAX=10
//    - NUM_BUTTONS=10
//    - function decode_code(code)->10-bit one-hot
//  Sub-module ps2_stable_filter: sample divider, candidate register, match/sample counters.
//    Outputs stable, timeout, candidate. Cleared by the FSM.
// TESTING (bench params SETTLE_CYCLES=4, SAMPLE_DIV=2, STABLE_COUNT=3, MAX_SAMPLES=8)
//  1. Reset, enable=1, code_in=3 held -> c1_upd pulses 11 cycles after SETTLE entry, c1=10'h004,
//     sel_out 0->1.
//  2. Next slot: code_in=10 -> c2=10'h200, c2_upd pulses once, c1 unchanged, sel_out 1->0.
//  3. code_in alternates 5/6 every sample -> no upd; err pulses after 8 samples; sel_out toggles;
//     c1 unchanged.
//  4. code_in=12 stable -> err pulse, no upd, vector unchanged, sel_out toggles.
//  5. enable=0 mid-SAMPLE for 5 cycles, then 1 -> no pulse while low; full 11-cycle latency from
//     re-enable on same sel_out.
//  6. code_in=0 stable with c1=10'h004 -> c1=0, c1_upd pulse;
//     PS2_PRESS_EDGE_EN: 0->7 gives c1_press=10'h040 for 1 cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and button-code definitions for the PS2 link scheduler.
// Codes 1..10 map to one-hot button bits; code 0 means no button pressed.
package ps2_pkg;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        SAMPLE  = 2'd1,
        PUBLISH = 2'd2,
        TIMEOUT = 2'd3
    } ps2_state_t;

    localparam int NUM_BUTTONS = 10;

    localparam logic [3:0] CODE_NONE     = 4'd0;
    localparam logic [3:0] CODE_CIRCLE   = 4'd1;
    localparam logic [3:0] CODE_CROSS    = 4'd2;
    localparam logic [3:0] CODE_SQUARE   = 4'd3;
    localparam logic [3:0] CODE_TRIANGLE = 4'd4;
    localparam logic [3:0] CODE_LEFT     = 4'd5;
    localparam logic [3:0] CODE_RIGHT    = 4'd6;
    localparam logic [3:0] CODE_UP       = 4'd7;
    localparam logic [3:0] CODE_DOWN     = 4'd8;
    localparam logic [3:0] CODE_R1       = 4'd9;
    localparam logic [3:0] CODE_START    = 4'd10;
    localparam logic [3:0] CODE_MAX      = CODE_START;

    function automatic logic [NUM_BUTTONS-1:0] decode_code(input logic [3:0] code);
        logic [NUM_BUTTONS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            vec[i] = (code == 4'(i + 1));
        end
        return vec;
    endfunction

    function automatic logic code_valid(input logic [3:0] code);
        return (code <= CODE_MAX);
    endfunction

endpackage

// File: rtl/ps2_stable_filter.sv
// Sample divider plus candidate/match/sample tracking for one controller slot.
// o_stable and o_timeout are single-cycle strobes on the deciding sample.
module ps2_stable_filter #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int STABLE_COUNT = 16,
    parameter int MAX_SAMPLES  = 64
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_clear,
    input  logic       i_run,
    input  logic [3:0] i_code,
    output logic       o_stable,
    output logic       o_timeout,
    output logic [3:0] o_candidate
);

    localparam int DIV_W   = $clog2(SAMPLE_DIV + 1);
    localparam int MATCH_W = $clog2(STABLE_COUNT + 1);
    localparam int SAMP_W  = $clog2(MAX_SAMPLES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(STABLE_COUNT - 1);
    localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(MAX_SAMPLES - 1);

    logic [DIV_W-1:0]   r_div;
    logic [MATCH_W-1:0] r_match;
    logic [SAMP_W-1:0]  r_samples;
    logic [3:0]         r_cand;

    logic w_tick;
    logic w_first;
    logic w_same;

    assign w_tick  = i_run && (r_div == DIV_LAST);
    assign w_first = (r_samples == '0);
    assign w_same  = !w_first && (i_code == r_cand);

    // Decide on the sample itself so the publish lands exactly STABLE_COUNT dividers in.
    assign o_stable    = w_tick && w_same && (r_match == MATCH_LAST);
    assign o_timeout   = w_tick && !o_stable && (r_samples == SAMP_LAST);
    assign o_candidate = r_cand;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_div     <= '0;
            r_match   <= '0;
            r_samples <= '0;
            r_cand    <= '0;
        end else if (i_run) begin
            if (w_tick) begin
                r_div     <= '0;
                r_samples <= r_samples + 1'b1;
                if (w_same) begin
                    r_match <= r_match + 1'b1;
                end else begin
                    r_cand  <= i_code;
                    r_match <= MATCH_W'(1);
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_link_scheduler.sv
// Alternates the shared 4-bit Arduino code link between two PS2 controllers.
// Define PS2_PRESS_EDGE_EN to add c1_press/c2_press newly-pressed pulse outputs.
module ps2_link_scheduler
    import ps2_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int SAMPLE_DIV    = 1000,
    parameter int STABLE_COUNT  = 16,
    parameter int MAX_SAMPLES   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             code_in,
    output logic                   sel_out,
    output logic [NUM_BUTTONS-1:0] c1,
    output logic [NUM_BUTTONS-1:0] c2,
    output logic                   c1_upd,
    output logic                   c2_upd,
    output logic                   err
`ifdef PS2_PRESS_EDGE_EN
    ,
    output logic [NUM_BUTTONS-1:0] c1_press,
    output logic [NUM_BUTTONS-1:0] c2_press
`endif
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    ps2_state_t r_state;
    ps2_state_t w_state_next;

    logic [3:0]             r_sync1;
    logic [3:0]             r_sync2;
    logic [SETTLE_W-1:0]    r_settle_cnt;
    logic                   r_sel;
    logic [NUM_BUTTONS-1:0] r_c1;
    logic [NUM_BUTTONS-1:0] r_c2;
    logic                   r_c1_upd;
    logic                   r_c2_upd;
    logic                   r_err;

    logic                   w_settle_last;
    logic                   w_run;
    logic                   w_filter_clear;
    logic                   w_stable;
    logic                   w_timeout;
    logic [3:0]             w_candidate;
    logic [NUM_BUTTONS-1:0] w_vec;
    logic                   w_valid;
    logic                   w_publish;
    logic                   w_abandon;

    assign w_settle_last  = (r_settle_cnt == SETTLE_LAST);
    assign w_run          = enable && (r_state == SAMPLE);
    assign w_filter_clear = !w_run;
    assign w_vec          = decode_code(w_candidate);
    assign w_valid        = code_valid(w_candidate);
    assign w_publish      = enable && (r_state == PUBLISH);
    assign w_abandon      = enable && (r_state == TIMEOUT);

    ps2_stable_filter #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .STABLE_COUNT (STABLE_COUNT),
        .MAX_SAMPLES  (MAX_SAMPLES)
    ) u_filter (
        .i_clk       (clock),
        .i_srst      (reset),
        .i_clear     (w_filter_clear),
        .i_run       (w_run),
        .i_code      (r_sync2),
        .o_stable    (w_stable),
        .o_timeout   (w_timeout),
        .o_candidate (w_candidate)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SETTLE:  if (w_settle_last) w_state_next = SAMPLE;
            SAMPLE: begin
                if (w_stable)       w_state_next = PUBLISH;
                else if (w_timeout) w_state_next = TIMEOUT;
            end
            PUBLISH: w_state_next = SETTLE;
            TIMEOUT: w_state_next = SETTLE;
            default: w_state_next = SETTLE;
        endcase
        // Dropping enable abandons the slot; the select line is left where it is.
        if (!enable) w_state_next = SETTLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= SETTLE;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_settle_cnt <= '0;
            r_sel        <= 1'b0;
            r_c1         <= '0;
            r_c2         <= '0;
            r_c1_upd     <= 1'b0;
            r_c2_upd     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_sync1  <= code_in;
            r_sync2  <= r_sync1;
            r_state  <= w_state_next;
            r_c1_upd <= 1'b0;
            r_c2_upd <= 1'b0;
            r_err    <= 1'b0;
            if (enable && (r_state == SETTLE) && !w_settle_last) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end
            if (w_publish) begin
                if (!w_valid) begin
                    r_err <= 1'b1;
                end else if (!r_sel) begin
                    r_c1     <= w_vec;
                    r_c1_upd <= 1'b1;
                end else begin
                    r_c2     <= w_vec;
                    r_c2_upd <= 1'b1;
                end
            end
            if (w_abandon) begin
                r_err <= 1'b1;
            end
            if (w_publish || w_abandon) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign sel_out = r_sel;
    assign c1      = r_c1;
    assign c2      = r_c2;
    assign c1_upd  = r_c1_upd;
    assign c2_upd  = r_c2_upd;
    assign err     = r_err;

`ifdef PS2_PRESS_EDGE_EN
    logic [NUM_BUTTONS-1:0] r_c1_press;
    logic [NUM_BUTTONS-1:0] r_c2_press;

    // Registered alongside the vector write so the press pulse lines up with its upd.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c1_press <= '0;
            r_c2_press <= '0;
        end else begin
            r_c1_press <= '0;
            r_c2_press <= '0;
            if (w_publish && w_valid) begin
                if (!r_sel) r_c1_press <= w_vec & ~r_c1;
                else        r_c2_press <= w_vec & ~r_c2;
            end
        end
    end

    assign c1_press = r_c1_press;
    assign c2_press = r_c2_press;
`endif

endmodule

// File: tb/tb_ps2_link_scheduler.sv
// Scoreboard bench for ps2_link_scheduler with short timing parameters.
// Each slot pushes its expected publish/error event; a negedge monitor pops and compares.
module tb_ps2_link_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       sel_out;
    logic [9:0] c1;
    logic [9:0] c2;
    logic       c1_upd;
    logic       c2_upd;
    logic       err;
`ifdef PS2_PRESS_EDGE_EN
    logic [9:0] c1_press;
    logic [9:0] c2_press;
`endif

    ps2_link_scheduler #(
        .SETTLE_CYCLES (4),
        .SAMPLE_DIV    (2),
        .STABLE_COUNT  (3),
        .MAX_SAMPLES   (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .code_in  (code_in),
        .sel_out  (sel_out),
        .c1       (c1),
        .c2       (c2),
        .c1_upd   (c1_upd),
        .c2_upd   (c2_upd),
        .err      (err)
`ifdef PS2_PRESS_EDGE_EN
        ,
        .c1_press (c1_press),
        .c2_press (c2_press)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       c1_upd;
        logic       c2_upd;
        logic       err;
        logic       sel_after;
        logic [9:0] c1;
        logic [9:0] c2;
        logic [9:0] p1;
        logic [9:0] p2;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mark     = 0;

    logic       m_sel = 1'b0;
    logic [9:0] m_c1  = '0;
    logic [9:0] m_c2  = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc=%0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [9:0] ref_vec(input logic [3:0] code);
        logic [9:0] one;
        one = 10'd1;
        if (code == 4'd0) return '0;
        return one << (code - 4'd1);
    endfunction

    task automatic push_code(input logic [3:0] code, input int lat);
        exp_t       e;
        logic [9:0] v;
        e.c1_upd = 1'b0; e.c2_upd = 1'b0; e.err = 1'b0;
        e.p1 = '0; e.p2 = '0; e.lat = lat;
        if (code <= 4'd10) begin
            v = ref_vec(code);
            if (!m_sel) begin
                e.c1_upd = 1'b1; e.p1 = v & ~m_c1; m_c1 = v;
            end else begin
                e.c2_upd = 1'b1; e.p2 = v & ~m_c2; m_c2 = v;
            end
        end else begin
            e.err = 1'b1;
        end
        m_sel = ~m_sel;
        e.c1 = m_c1; e.c2 = m_c2; e.sel_after = m_sel;
        exp_q.push_back(e);
    endtask

    task automatic push_timeout(input int lat);
        exp_t e;
        e.c1_upd = 1'b0; e.c2_upd = 1'b0; e.err = 1'b1;
        e.p1 = '0; e.p2 = '0; e.lat = lat;
        m_sel = ~m_sel;
        e.c1 = m_c1; e.c2 = m_c2; e.sel_after = m_sel;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_slot();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            step(1);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check_val("slot_wait", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset && (c1_upd || c2_upd || err)) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_pulse", {29'd0, c1_upd, c2_upd, err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn cyc=%0d sel=%0b c1=%h c2=%h c1_upd=%0b c2_upd=%0b err=%0b lat=%0d",
                             cyc, sel_out, c1, c2, c1_upd, c2_upd, err, cyc - mark);
                    check_val("c1_upd", c1_upd, e.c1_upd);
                    check_val("c2_upd", c2_upd, e.c2_upd);
                    check_val("err", err, e.err);
                    check_val("c1", c1, e.c1);
                    check_val("c2", c2, e.c2);
                    check_val("sel_out", sel_out, e.sel_after);
                    check_val("latency", cyc - mark, e.lat);
`ifdef PS2_PRESS_EDGE_EN
                    check_val("c1_press", c1_press, e.p1);
                    check_val("c2_press", c2_press, e.p2);
`endif
                    mark = cyc;
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        code_in = 4'd3;
        step(3);
        check_val("rst_sel", sel_out, 0);
        check_val("rst_c1", c1, 0);
        check_val("rst_c2", c2, 0);
        check_val("rst_pulses", {c1_upd, c2_upd, err}, 0);

        // 1: code 3 on controller 1
        push_code(4'd3, 11);
        reset = 1'b0;
        mark  = cyc;
        wait_slot();

        // 2: code 10 on controller 2
        code_in = 4'd10;
        push_code(4'd10, 11);
        wait_slot();

        // 3: alternating 5/6 never settles -> timeout after 8 samples
        push_timeout(21);
        for (int i = 0; i < 10; i++) begin
            code_in = (i % 2 == 1) ? 4'd6 : 4'd5;
            step(2);
        end
        wait_slot();

        // 4: invalid code 12
        code_in = 4'd12;
        push_code(4'd12, 11);
        wait_slot();

        // 5: enable low mid-SAMPLE for 5 cycles
        code_in = 4'd3;
        push_code(4'd3, 11);
        step(6);
        enable = 1'b0;
        mark   = cyc;
        step(5);
        check_val("hold_sel", sel_out, 0);
        check_val("hold_c1", c1, 10'h004);
        enable = 1'b1;
        mark   = cyc;
        wait_slot();

        // 6..9: release/press sequences
        code_in = 4'd10;
        push_code(4'd10, 11);
        wait_slot();
        code_in = 4'd0;
        push_code(4'd0, 11);
        wait_slot();
        code_in = 4'd8;
        push_code(4'd8, 11);
        wait_slot();
        code_in = 4'd7;
        push_code(4'd7, 11);
        wait_slot();

        // Reset mid-slot on controller 2 returns to controller 1
        step(7);
        reset = 1'b1;
        step(1);
        check_val("rst_mid_sel", sel_out, 0);
        check_val("rst_mid_c1", c1, 0);
        check_val("rst_mid_c2", c2, 0);
        m_sel = 1'b0; m_c1 = '0; m_c2 = '0;
        code_in = 4'd4;
        push_code(4'd4, 11);
        reset = 1'b0;
        mark  = cyc;
        wait_slot();
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
